// File: rtl/arb_req_queue.sv
// Four-channel request buffer in front of a 4-way round-robin arbiter.
// Each channel is a small FIFO; the granted head is popped onto one shared output.
module arb_req_queue #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      req,
  input  logic [3:0]      gnt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic            gnt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Handshake: a push on channel n happens on any rising edge where
  // in_valid[n] & in_ready[n]; a pop happens where gnt[n] is the lowest set
  // gnt bit and the channel is non-empty. There is no output backpressure.

  logic [DW-1:0] mem [4][DEPTH];
  logic [AW-1:0] wr_ptr [4];
  logic [AW-1:0] rd_ptr [4];
  logic [CW-1:0] cnt    [4];

  logic [3:0]    push;
  logic [3:0]    pop;
  logic [3:0]    empty;
  logic [3:0]    gnt_low;
  logic          gnt_multi;
  logic          err_now;
  logic [DW-1:0] pop_data;
  logic [1:0]    pop_id;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i]    = (cnt[i] == '0);
      in_ready[i] = (cnt[i] != CNT_FULL);
      push[i]     = in_valid[i] & in_ready[i];
      // The entry being popped this cycle is not requested again, so the
      // arbiter's one-cycle grant latency never causes an over-grant.
      req[i]      = (cnt[i] > CNT_ONE) | ((cnt[i] == CNT_ONE) & ~gnt[i]);
    end
  end

  always_comb begin
    gnt_low   = gnt & (~gnt + 4'd1);
    gnt_multi = ((gnt & (gnt - 4'd1)) != 4'd0);
    pop       = gnt_low & ~empty;
    err_now   = gnt_multi | ((gnt & empty) != 4'd0);
  end

  always_comb begin
    pop_data = '0;
    pop_id   = '0;
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        pop_data = mem[i][rd_ptr[i]];
        pop_id   = 2'(i);
      end
    end
  end

  // Storage has no reset; contents are meaningless once the counts clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      gnt_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      out_valid <= |pop;
      if (|pop) begin
        out_data <= pop_data;
        out_id   <= pop_id;
      end
      if (err_now) gnt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_arb_req_queue;

  localparam int DW = 8;

  logic          clk;
  logic          rstn;
  logic [3:0]    in_valid;
  logic [31:0]   in_data;
  logic [3:0]    in_ready;
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [1:0]    out_id;
  logic          gnt_err;

  int n_checks;
  int n_fail;
  logic [DW-1:0] exp_q[$];

  arb_req_queue #(.DW(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .gnt_err   (gnt_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic next_cyc();
    @(negedge clk);
    in_valid = '0;
    gnt      = '0;
  endtask

  task automatic set_push(input int ch, input logic [7:0] d);
    in_valid[ch]      = 1'b1;
    in_data[ch*8 +: 8] = d;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] id);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_id"}, out_id, id);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    in_valid = '0;
    in_data  = '0;
    gnt      = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", req, 4'b0000);
    check("rst_in_ready", in_ready, 4'b1111);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_id", out_id, 2'd0);
    check("rst_gnt_err", gnt_err, 1'b0);
    rstn = 1'b1;

    // single beat on ch2
    next_cyc(); set_push(2, 8'hA5);
    next_cyc(); #1;
    check("sb_req", req, 4'b0100);
    check("sb_in_ready0", in_ready, 4'b1111);
    gnt = 4'b0100; #1;
    check("sb_req_in_gnt", req, 4'b0000);
    check("sb_in_ready1", in_ready, 4'b1111);
    next_cyc(); #1;
    check_out("sb_out", 8'hA5, 2'd2);
    check("sb_req_after", req, 4'b0000);
    next_cyc(); #1;
    check("sb_valid_drop", out_valid, 1'b0);
    check("sb_data_hold", out_data, 8'hA5);
    check("sb_id_hold", out_id, 2'd2);

    // fill ch0, fifth push dropped
    for (int k = 0; k < 5; k++) begin
      next_cyc(); #1;
      check("fill_in_ready", in_ready[0], (k < 4) ? 1'b1 : 1'b0);
      set_push(0, 8'(8'h10 + k));
      if (k < 4) exp_q.push_back(8'(8'h10 + k));
    end
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      gnt = 4'b0001; #1;
      check("full_req0", req[0], (k < 3) ? 1'b1 : 1'b0);
      check("full_in_ready0", in_ready[0], (k > 0) ? 1'b1 : 1'b0);
      if (k > 0) check_out("full_out", exp_q.pop_front(), 2'd0);
    end
    next_cyc(); #1;
    check_out("full_last", exp_q.pop_front(), 2'd0);
    check("full_req_empty", req, 4'b0000);
    check("full_in_ready_end", in_ready, 4'b1111);

    // back-to-back grants on ch1
    next_cyc(); set_push(1, 8'h21);
    next_cyc(); set_push(1, 8'h22);
    next_cyc(); gnt = 4'b0010; #1;
    check("b2b_req1_first", req[1], 1'b1);
    next_cyc(); gnt = 4'b0010; #1;
    check("b2b_req1_second", req[1], 1'b0);
    check_out("b2b_out0", 8'h21, 2'd1);
    next_cyc(); #1;
    check_out("b2b_out1", 8'h22, 2'd1);
    next_cyc(); #1;
    check("b2b_idle", out_valid, 1'b0);

    // simultaneous push/pop on ch3
    next_cyc(); set_push(3, 8'h30);
    next_cyc(); set_push(3, 8'h31); gnt = 4'b1000; #1;
    check("sim_req3_gnt", req[3], 1'b0);
    next_cyc(); #1;
    check_out("sim_out0", 8'h30, 2'd3);
    check("sim_req3_next", req, 4'b1000);
    check("sim_in_ready", in_ready, 4'b1111);
    gnt = 4'b1000;
    next_cyc(); #1;
    check_out("sim_out1", 8'h31, 2'd3);
    check("sim_req_empty", req, 4'b0000);
    check("sim_no_err", gnt_err, 1'b0);

    // grant to empty channel
    next_cyc(); gnt = 4'b0010;
    next_cyc(); #1;
    check("err_empty_flag", gnt_err, 1'b1);
    check("err_empty_valid", out_valid, 1'b0);
    next_cyc(); #1;
    check("err_sticky", gnt_err, 1'b1);

    // multiple grant bits: only ch0 pops
    next_cyc(); set_push(0, 8'h40); set_push(2, 8'h42);
    next_cyc(); gnt = 4'b0101;
    next_cyc(); #1;
    check_out("multi_out", 8'h40, 2'd0);
    check("multi_req", req, 4'b0100);
    gnt = 4'b0100;
    next_cyc(); #1;
    check_out("multi_ch2", 8'h42, 2'd2);
    check("multi_req_end", req, 4'b0000);

    // reset mid-operation
    next_cyc(); for (int c = 0; c < 4; c++) set_push(c, 8'(8'h60 + c));
    next_cyc(); for (int c = 0; c < 4; c++) set_push(c, 8'(8'h70 + c));
    next_cyc(); #1;
    check("mid_req_full", req, 4'b1111);
    gnt = 4'b0001;
    next_cyc(); #1;
    check_out("mid_pre_out", 8'h60, 2'd0);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_req", req, 4'b0000);
    check("mid_rst_in_ready", in_ready, 4'b1111);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_err", gnt_err, 1'b0);
    #1 rstn = 1'b1;
    next_cyc(); set_push(0, 8'h55);
    next_cyc(); gnt = 4'b0001;
    next_cyc(); #1;
    check_out("mid_new", 8'h55, 2'd0);
    check("mid_req_after", req, 4'b0000);
    gnt = 4'b0010;
    next_cyc(); #1;
    check("mid_flushed_valid", out_valid, 1'b0);
    check("mid_flushed_err", gnt_err, 1'b1);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_req_queue.md
# arb_req_queue

Four-channel request buffer sitting directly upstream of the 4-way round-robin arbiter. Each channel holds a small FIFO of command words and drives that channel's `req` into the arbiter. On the arbiter's registered `gnt` pulse, the block pops the granted head and presents it on a single shared output port. Its `req` generation accounts for the arbiter's one-cycle grant latency, so a channel is never granted more times than it has entries.

## Interface
- `DW`, 8: command word width.
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  4  per-channel push strobe.
- `in_data`  in  4*DW  per-channel push data; channel n occupies bits [n*DW +: DW].
- `in_ready`  out  4  per-channel not-full.
- `req`  out  4  request to arbiter, bit n = channel n.
- `gnt`  in  4  grant from arbiter, bit n = channel n; registered, single-cycle per grant.
- `out_valid`  out  1  registered; popped word is valid this cycle.
- `out_data`  out  DW  popped word.
- `out_id`  out  2  channel the popped word came from.
- `gnt_err`  out  1  sticky protocol-error flag.

## Operation
- Per channel: circular FIFO with write pointer, read pointer, and count (0..DEPTH, width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Push: accepted when `in_valid[n] & in_ready[n]`. `in_ready[n] = (count_n != DEPTH)`.
- Push while full is dropped silently. A same-cycle pop does not make room for it.
- Pop: occurs on the edge ending a cycle where `gnt[n]` is honoured. A grant is honoured when it is the lowest set bit of `gnt` and `count_n != 0`.
- Pop actions: read pointer advances, count decrements, and `out_data`/`out_id`/`out_valid` are loaded.
- Simultaneous push and pop on one non-full channel: count unchanged, both pointers advance.
- `req[n]` is combinational from count and gnt: `req[n] = (count_n > 1) | (count_n == 1 & ~gnt[n])`. The entry being popped in a grant cycle is therefore not requested again, which prevents a spurious grant one cycle later.
- No output backpressure: consumers must accept every `out_valid` beat.
- Errors set `gnt_err`, which stays set until reset:
  - `gnt[n]` with `count_n == 0`: grant ignored, nothing popped.
  - More than one `gnt` bit set: only the lowest is honoured, the others are ignored and pop nothing.
- Cycles with no honoured grant: `out_valid` is 0 and `out_data`/`out_id` hold their last values.

## Timing
- Reset values:
  - all counts and pointers 0
  - `req` 4'b0000, `in_ready` 4'b1111
  - `out_valid` 0, `out_data` 0, `out_id` 0
  - `gnt_err` 0
- Reset asserted mid-operation: all FIFOs flush immediately (asynchronous), in-flight grants are discarded, and FIFO contents are not preserved.
- Push at edge E0 → `req[n]` high from E0 → arbiter `gnt[n]` high after E1 → `out_valid` high after E2. End-to-end latency is 2 cycles after push acceptance.
- Grant to output latency: 1 cycle (`gnt[n]` sampled at edge Ek, `out_valid` high during the cycle after Ek).
- Back-to-back grants to one channel with count ≥2 produce consecutive `out_valid` beats in FIFO order.
- `in_ready[n]` deasserts during the cycle after the push that fills the FIFO. It reasserts during the cycle after the first pop from full.

## Test plan
- Single beat: push 0xA5 on ch2.
  - `req` = 4'b0100 the next cycle.
  - Drive `gnt[2]` = 1 for one cycle: during that cycle `req[2]` = 0.
  - One cycle later: `out_valid` = 1, `out_data` = 0xA5, `out_id` = 2.
  - `in_ready[2]` = 1 throughout.
- Full/drop: push 0x10..0x14 on ch0 on consecutive cycles.
  - `in_ready[0]` = 0 after the 4th push; 0x14 is dropped.
  - Four grants to ch0 yield 0x10, 0x11, 0x12, 0x13 in order, and `req[0]` = 0 during the 4th grant cycle.
- Back-to-back grants: ch1 holds {0x21, 0x22}; `gnt` = 4'b0010 for 2 consecutive cycles.
  - Output is 0x21 then 0x22 on consecutive cycles.
  - `req[1]` = 1 during the first grant cycle and 0 during the second.
- Simultaneous push/pop: ch3 holds 0x30; push 0x31 in the same cycle as `gnt[3]`.
  - Output is 0x30, count stays 1, `req[3]` = 1 the next cycle, and the next grant yields 0x31.
- Errors:
  - `gnt[1]` with ch1 empty → `gnt_err` = 1, `out_valid` = 0, and `gnt_err` stays 1.
  - `gnt` = 4'b0101 with both ch0 and ch2 non-empty → only ch0 pops, and ch2's count is unchanged.
- Reset mid-op: fill ch0–ch3 with 2 entries each, then pulse `rstn` low between edges.
  - Immediately: `req` = 0, `in_ready` = 4'b1111, `out_valid` = 0.
  - After release, a single push on ch0 followed by one grant outputs only the new word.
